uart_tx: RTL and testbench

Serial transmitter for the team's 4-bit UART link. It takes parallel nibbles through a valid/ready handshake and serialises each one as a 6-bit frame: start bit, data bits d0..d3 LSB first, stop bit. Each bit carries a one-cycle valid strobe, so `tx_dout`/`tx_vout` drive the receiver's `rx_din`/`rx_vin` directly. A one-entry holding register allows back-to-back frames with no idle gap.

---
 rtl/uart_tx_if.sv | 28 ++
 rtl/uart_tx.sv | 149 ++++++++++++++
 tb/tb_uart_tx.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Handshake and serial-output bundle for the 4-bit UART transmitter.
// The master side supplies nibbles; the slave side is the transmitter.
interface uart_tx_if;
  logic [3:0] tx_din;
  logic       tx_vin;
  logic       tx_rdy;
  logic       tx_dout;
  logic       tx_vout;
  logic       tx_busy;

  modport master (
    output tx_din,
    output tx_vin,
    input  tx_rdy,
    input  tx_dout,
    input  tx_vout,
    input  tx_busy
  );

  modport slave (
    input  tx_din,
    input  tx_vin,
    output tx_rdy,
    output tx_dout,
    output tx_vout,
    output tx_busy
  );
endinterface

// File: rtl/uart_tx.sv
// Nibble serialiser: start, d0..d3 LSB first, stop, with a per-bit valid strobe.
// A one-entry holding register lets the next frame start right after the stop bit.
module uart_tx #(
  parameter int BIT_PERIOD = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  uart_tx_if.slave  tx_if
);

  localparam int          DATA_BITS = 4;
  localparam logic [7:0]  PER_LAST  = 8'(BIT_PERIOD - 1);
  localparam logic [2:0]  BIT_LAST  = 3'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  per_q, per_d;
  logic [2:0]  bit_q, bit_d;
  logic [3:0]  shift_q, shift_d;
  logic [3:0]  hold_data_q, hold_data_d;
  logic        hold_valid_q, hold_valid_d;
  logic        dout_q, dout_d;
  logic        vout_q, vout_d;
  logic        per_last;
  logic        accept;
  logic        direct;

  assign tx_if.tx_rdy  = ~hold_valid_q;
  assign tx_if.tx_busy = (state_q != TX_IDLE) || hold_valid_q;
  assign tx_if.tx_dout = dout_q;
  assign tx_if.tx_vout = vout_q;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d      = state_q;
    per_d        = per_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    hold_data_d  = hold_data_q;
    hold_valid_d = hold_valid_q;

    per_last = (per_q == PER_LAST);
    accept   = tx_if.tx_vin && !hold_valid_q;
    direct   = accept && ((state_q == TX_IDLE) || ((state_q == TX_STOP) && per_last));

    case (state_q)
      TX_IDLE: begin
        if (direct) begin
          shift_d = tx_if.tx_din;
          per_d   = 8'd0;
          bit_d   = 3'd0;
          state_d = TX_START;
        end else begin
          per_d   = 8'd0;
        end
      end
      TX_START: begin
        if (per_last) begin
          per_d   = 8'd0;
          bit_d   = 3'd0;
          state_d = TX_DATA;
        end else begin
          per_d   = per_q + 8'd1;
        end
      end
      TX_DATA: begin
        if (per_last) begin
          per_d   = 8'd0;
          shift_d = {1'b0, shift_q[3:1]};
          if (bit_q == BIT_LAST) begin
            bit_d   = 3'd0;
            state_d = TX_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          per_d   = per_q + 8'd1;
        end
      end
      TX_STOP: begin
        if (per_last) begin
          per_d = 8'd0;
          // A held nibble has priority; a direct accept is only possible when the holder is empty
          if (hold_valid_q) begin
            shift_d      = hold_data_q;
            hold_valid_d = 1'b0;
            state_d      = TX_START;
          end else if (direct) begin
            shift_d      = tx_if.tx_din;
            state_d      = TX_START;
          end else begin
            state_d      = TX_IDLE;
          end
        end else begin
          per_d = per_q + 8'd1;
        end
      end
      default: begin
        state_d = TX_IDLE;
        per_d   = 8'd0;
        bit_d   = 3'd0;
      end
    endcase

    if (accept && !direct) begin
      hold_data_d  = tx_if.tx_din;
      hold_valid_d = 1'b1;
    end else begin
      hold_data_d  = hold_data_d;
    end

    case (state_d)
      TX_START: dout_d = 1'b0;
      TX_DATA:  dout_d = shift_d[0];
      default:  dout_d = 1'b1;
    endcase
    vout_d = (state_d != TX_IDLE) && (per_d == 8'd0);
  end

  // State, counters, storage and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= TX_IDLE;
      per_q        <= 8'd0;
      bit_q        <= 3'd0;
      shift_q      <= 4'd0;
      hold_data_q  <= 4'd0;
      hold_valid_q <= 1'b0;
      dout_q       <= 1'b1;
      vout_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      per_q        <= per_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      hold_data_q  <= hold_data_d;
      hold_valid_q <= hold_valid_d;
      dout_q       <= dout_d;
      vout_q       <= vout_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: channel 0 runs BIT_PERIOD=1, channel 1 runs BIT_PERIOD=3.
// A negedge monitor decodes frames from the strobes and checks them against queued nibbles.
module tb_uart_tx;
  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_bad;

  uart_tx_if if0 ();
  uart_tx_if if1 ();

  logic       vin  [2];
  logic [3:0] din  [2];
  logic       rdy  [2];
  logic       dout [2];
  logic       vout [2];
  logic       busy [2];

  assign if0.tx_vin = vin[0];
  assign if0.tx_din = din[0];
  assign if1.tx_vin = vin[1];
  assign if1.tx_din = din[1];
  assign rdy[0]  = if0.tx_rdy;
  assign dout[0] = if0.tx_dout;
  assign vout[0] = if0.tx_vout;
  assign busy[0] = if0.tx_busy;
  assign rdy[1]  = if1.tx_rdy;
  assign dout[1] = if1.tx_dout;
  assign vout[1] = if1.tx_vout;
  assign busy[1] = if1.tx_busy;

  uart_tx #(.BIT_PERIOD(1)) u0 (.clk(clk), .rst_n(rst_n), .tx_if(if0));
  uart_tx #(.BIT_PERIOD(3)) u1 (.clk(clk), .rst_n(rst_n), .tx_if(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0] sb0 [$];
  logic [3:0] sb1 [$];
  int         stb_cyc0 [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame monitor: per-channel strobe spacing, held levels, idle level and frame content
  int   bc   [2];
  logic fr   [2][6];
  logic lvl  [2];
  int   last [2];
  int   nstb [2];
  int   bp   [2] = '{1, 3};

  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (!rst_n) begin
        bc[c] = 0;
      end else if (vout[c]) begin
        if (bc[c] > 0) chk("strobe_spacing", cyc - last[c], bp[c]);
        fr[c][bc[c]] = dout[c];
        lvl[c]  = dout[c];
        last[c] = cyc;
        nstb[c]++;
        if (c == 0) stb_cyc0.push_back(cyc);
        bc[c]++;
        if (bc[c] == 6) begin
          logic [3:0] got;
          logic [3:0] exp;
          bc[c] = 0;
          chk("start_bit", fr[c][0], 1'b0);
          chk("stop_bit", fr[c][5], 1'b1);
          got = {fr[c][4], fr[c][3], fr[c][2], fr[c][1]};
          if ((c == 0 && sb0.size() == 0) || (c == 1 && sb1.size() == 0)) begin
            chk("unexpected_frame", got, 32'hFFFF_FFFF);
          end else begin
            exp = (c == 0) ? sb0.pop_front() : sb1.pop_front();
            chk("frame_data", got, exp);
          end
        end
      end else if (bc[c] == 0) begin
        chk("idle_level", dout[c], 1'b1);
      end else begin
        chk("bit_hold", dout[c], lvl[c]);
      end
    end
  end

  // Call at a negedge; returns at the negedge after the accepting edge with tx_vin still high
  task automatic send(input int c, input logic [3:0] nib, output int acc);
    int k;
    acc    = -1;
    din[c] = nib;
    vin[c] = 1'b1;
    for (k = 0; k < 100; k++) begin
      if (rdy[c]) break;
      @(negedge clk);
    end
    if (k == 100) begin
      chk("send_timeout", 32'd0, 32'd1);
    end else begin
      acc = cyc;
      if (c == 0) sb0.push_back(nib);
      else        sb1.push_back(nib);
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input int c, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      if (!busy[c]) break;
      @(negedge clk);
    end
    chk("idle_timeout", busy[c], 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       seq_a [6];
    logic       seq_5 [6];
    logic [3:0] perm  [16];
    int         acc0, acc1, acc2, s0;
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      vin[c] = 1'b0;
      din[c] = 4'd0;
      bc[c] = 0; nstb[c] = 0; last[c] = 0; lvl[c] = 1'b1;
    end
    seq_a = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    seq_5 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    // Reset
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      chk("rst_dout", dout[c], 1'b1);
      chk("rst_vout", vout[c], 1'b0);
      chk("rst_rdy",  rdy[c],  1'b1);
      chk("rst_busy", busy[c], 1'b0);
    end
    s0 = nstb[0] + nstb[1];
    repeat (5) @(negedge clk);
    chk("rst_no_strobes", nstb[0] + nstb[1], s0);

    // Single frame 4'hA at BIT_PERIOD=1
    send(0, 4'hA, acc0);
    vin[0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("single_dout", dout[0], seq_a[i]);
      chk("single_vout", vout[0], 1'b1);
      @(negedge clk);
    end
    chk("single_idle_dout", dout[0], 1'b1);
    chk("single_idle_vout", vout[0], 1'b0);
    chk("single_idle_busy", busy[0], 1'b0);

    // Back-to-back 3, C, then 6 stalls until C reaches the shifter
    repeat (2) @(negedge clk);
    stb_cyc0.delete();
    send(0, 4'h3, acc0);
    send(0, 4'hC, acc1);
    chk("b2b_rdy_low_held", rdy[0], 1'b0);
    chk("b2b_busy", busy[0], 1'b1);
    send(0, 4'h6, acc2);
    vin[0] = 1'b0;
    chk("b2b_stall_cycles", acc2 - acc0, 7);
    wait_idle(0, 60);
    chk("b2b_strobe_count", stb_cyc0.size(), 18);
    for (int i = 1; i < stb_cyc0.size(); i++)
      chk("b2b_contiguous", stb_cyc0[i] - stb_cyc0[i-1], 1);

    // BIT_PERIOD=3, nibble 4'h5
    send(1, 4'h5, acc0);
    vin[1] = 1'b0;
    for (int i = 0; i < 18; i++) begin
      chk("bp3_dout", dout[1], seq_5[i/3]);
      chk("bp3_vout", vout[1], (i % 3) == 0);
      chk("bp3_busy", busy[1], 1'b1);
      @(negedge clk);
    end
    chk("bp3_frame_end_busy", busy[1], 1'b0);
    chk("bp3_frame_end_dout", dout[1], 1'b1);

    // Loopback of all 16 nibbles in shuffled order, vin held high throughout
    for (int i = 0; i < 16; i++) perm[i] = 4'(i);
    for (int i = 15; i > 0; i--) begin
      int j;
      logic [3:0] t;
      j = int'($urandom_range(i, 0));
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int i = 0; i < 16; i++) send(0, perm[i], acc0);
    vin[0] = 1'b0;
    wait_idle(0, 200);
    chk("loopback_drained", sb0.size(), 0);

    // Reset during d1 with a nibble held
    send(0, 4'h9, acc0);
    send(0, 4'h7, acc1);
    vin[0] = 1'b0;
    @(negedge clk);
    chk("midrst_at_d1_strobe", vout[0], 1'b1);
    chk("midrst_hold_before", u0.hold_valid_q, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_dout", dout[0], 1'b1);
    chk("midrst_vout", vout[0], 1'b0);
    chk("midrst_rdy",  rdy[0],  1'b1);
    chk("midrst_busy", busy[0], 1'b0);
    chk("midrst_hold_valid", u0.hold_valid_q, 1'b0);
    sb0.delete();
    @(negedge clk);
    rst_n = 1'b1;
    s0 = nstb[0];
    repeat (20) @(negedge clk);
    chk("midrst_no_strobes", nstb[0], s0);
    chk("end_sb0_empty", sb0.size(), 0);
    chk("end_sb1_empty", sb1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
